// File: rtl/vseq_pkg.sv
// Shared types and entry-layout helpers for the vector sequencer.
// An entry is packed {valid, cw, expect, mask} with mask in the LSBs.
package vseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_APPLY    = 3'd2,
        ST_SETTLE_W = 3'd3,
        ST_CHECK    = 3'd4,
        ST_DONE     = 3'd5
    } vseq_state_t;

    function automatic int valid_bit(input int cw_w, input int obs_w);
        return 2 * obs_w + cw_w;
    endfunction

    function automatic int cw_lsb(input int obs_w);
        return 2 * obs_w;
    endfunction

    function automatic int exp_lsb(input int obs_w);
        return obs_w;
    endfunction

    function automatic int mask_lsb();
        return 0;
    endfunction

endpackage

// File: rtl/vseq_ram.sv
// Simple dual-port vector RAM: one synchronous write port, one read port
// with a single cycle of read latency. Contents are not affected by reset.
module vseq_ram #(
    parameter int WIDTH  = 58,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vector_sequencer.sv
// Replays stored control words into the ALU datapath, compares the masked
// observation after a settle delay, and records error statistics.
module vector_sequencer
    import vseq_pkg::*;
#(
    parameter int CW_WIDTH  = 41,
    parameter int OBS_WIDTH = 8,
    parameter int DEPTH     = 64,
    parameter int SETTLE    = 1,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int ENTRY_W   = 1 + CW_WIDTH + 2 * OBS_WIDTH
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Load_En,
    input  logic [ADDR_W-1:0]    Load_Addr,
    input  logic [ENTRY_W-1:0]   Load_Data,
    input  logic                 Start,
    input  logic                 Stop_On_Err,
    input  logic [OBS_WIDTH-1:0] Obs_In,
    output logic [CW_WIDTH-1:0]  Ctrl_Out,
    output logic                 Ctrl_Valid,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Pass,
    output logic [ADDR_W:0]      Err_Count,
    output logic [ADDR_W:0]      Vec_Count,
    output logic [ADDR_W-1:0]    Fail_Addr,
    output vseq_state_t          Dbg_State
);

    localparam int VALID_BIT = valid_bit(CW_WIDTH, OBS_WIDTH);
    localparam int CW_LSB    = cw_lsb(OBS_WIDTH);
    localparam int EXP_LSB   = exp_lsb(OBS_WIDTH);
    localparam int MASK_LSB  = mask_lsb();

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE     = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE     = (ADDR_W + 1)'(1);
    localparam logic [3:0]        SETTLE_INIT = 4'(SETTLE);

    vseq_state_t          state, next_state;
    logic [ADDR_W-1:0]    ptr;
    logic [ENTRY_W-1:0]   rd_data;
    logic [OBS_WIDTH-1:0] exp_r, mask_r;
    logic [3:0]           settle_cnt;
    logic                 stop_lat;
    logic                 mismatch;
    logic                 entry_valid;
    logic [CW_WIDTH-1:0]  entry_cw;

    // The RAM is only writable while no run is consuming it.
    vseq_ram #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .Clock   (Clock),
        .wr_en   (Load_En && !Busy),
        .wr_addr (Load_Addr),
        .wr_data (Load_Data),
        .rd_addr (ptr),
        .rd_data (rd_data)
    );

    assign entry_valid = rd_data[VALID_BIT];
    assign entry_cw    = rd_data[CW_LSB +: CW_WIDTH];
    assign mismatch    = |((Obs_In ^ exp_r) & mask_r);

    assign Busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign Done      = (state == ST_DONE);
    assign Pass      = Done && (Err_Count == '0);
    assign Dbg_State = state;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: if (Start) next_state = ST_FETCH;
            ST_FETCH:         next_state = ST_APPLY;
            ST_APPLY: begin
                if (!entry_valid)     next_state = ST_DONE;
                else if (SETTLE == 0) next_state = ST_CHECK;
                else                  next_state = ST_SETTLE_W;
            end
            ST_SETTLE_W:      if (settle_cnt <= 4'd1) next_state = ST_CHECK;
            ST_CHECK: begin
                if ((ptr == LAST_ADDR) || (mismatch && stop_lat)) next_state = ST_DONE;
                else                                              next_state = ST_FETCH;
            end
            default:          next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            Ctrl_Out   <= '0;
            Ctrl_Valid <= 1'b0;
            Err_Count  <= '0;
            Vec_Count  <= '0;
            Fail_Addr  <= '0;
            exp_r      <= '0;
            mask_r     <= '0;
            settle_cnt <= '0;
            stop_lat   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        ptr       <= '0;
                        Err_Count <= '0;
                        Vec_Count <= '0;
                        Fail_Addr <= '0;
                        stop_lat  <= Stop_On_Err;
                    end
                end
                ST_APPLY: begin
                    if (entry_valid) begin
                        Ctrl_Out   <= entry_cw;
                        Ctrl_Valid <= 1'b1;
                        exp_r      <= rd_data[EXP_LSB +: OBS_WIDTH];
                        mask_r     <= rd_data[MASK_LSB +: OBS_WIDTH];
                        settle_cnt <= SETTLE_INIT;
                    end else begin
                        Ctrl_Valid <= 1'b0;
                    end
                end
                ST_SETTLE_W: settle_cnt <= settle_cnt - 4'd1;
                ST_CHECK: begin
                    Vec_Count <= Vec_Count + CNT_ONE;
                    if (mismatch) begin
                        if (Err_Count != '1) Err_Count <= Err_Count + CNT_ONE;
                        // An empty error count means this is the run's first failure.
                        if (Err_Count == '0) Fail_Addr <= ptr;
                    end
                    if (next_state == ST_FETCH) ptr        <= ptr + PTR_ONE;
                    else                        Ctrl_Valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer: directed and randomized vector tables checked
// against a table-walking reference model and a per-vector Ctrl_Out trace.
module tb_vector_sequencer;
    import vseq_pkg::*;

    localparam int CW    = 41;
    localparam int OBS   = 8;
    localparam int DEPTH = 64;
    localparam int STL   = 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int EW    = 1 + CW + 2 * OBS;
    localparam int LAT   = STL + 3;

    logic           Clock, Reset, Load_En, Start, Stop_On_Err;
    logic [AW-1:0]  Load_Addr;
    logic [EW-1:0]  Load_Data;
    logic [OBS-1:0] Obs_In;
    logic [CW-1:0]  Ctrl_Out;
    logic           Ctrl_Valid, Busy, Done, Pass;
    logic [AW:0]    Err_Count, Vec_Count;
    logic [AW-1:0]  Fail_Addr;
    vseq_state_t    dbg_state;

    // The datapath under test simply echoes the low byte of its control word.
    assign Obs_In = Ctrl_Out[OBS-1:0];

    vector_sequencer #(
        .CW_WIDTH (CW), .OBS_WIDTH (OBS), .DEPTH (DEPTH), .SETTLE (STL)
    ) dut (
        .Clock (Clock), .Reset (Reset), .Load_En (Load_En), .Load_Addr (Load_Addr),
        .Load_Data (Load_Data), .Start (Start), .Stop_On_Err (Stop_On_Err),
        .Obs_In (Obs_In), .Ctrl_Out (Ctrl_Out), .Ctrl_Valid (Ctrl_Valid),
        .Busy (Busy), .Done (Done), .Pass (Pass), .Err_Count (Err_Count),
        .Vec_Count (Vec_Count), .Fail_Addr (Fail_Addr), .Dbg_State (dbg_state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic           m_valid [DEPTH];
    logic [CW-1:0]  m_cw    [DEPTH];
    logic [OBS-1:0] m_exp   [DEPTH];
    logic [OBS-1:0] m_mask  [DEPTH];
    logic [CW-1:0]  exp_q[$];
    int tests_run;
    int tests_failed;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every CHECK cycle must present the next expected control word.
    always @(negedge Clock) begin
        if (Reset && dbg_state == ST_CHECK) begin
            if (exp_q.size() == 0) begin
                check("trace_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                check("trace_cw", 64'(Ctrl_Out), 64'(exp_q.pop_front()));
                check("trace_valid", 64'(Ctrl_Valid), 64'd1);
            end
        end
    end

    task automatic set_model(input int a, input logic v, input logic [CW-1:0] cw,
                             input logic [OBS-1:0] e, input logic [OBS-1:0] m);
        m_valid[a] = v; m_cw[a] = cw; m_exp[a] = e; m_mask[a] = m;
    endtask

    task automatic load(input int a, input logic v, input logic [CW-1:0] cw,
                        input logic [OBS-1:0] e, input logic [OBS-1:0] m);
        @(negedge Clock);
        Load_En = 1'b1; Load_Addr = AW'(a); Load_Data = {v, cw, e, m};
        @(negedge Clock);
        Load_En = 1'b0;
        set_model(a, v, cw, e, m);
    endtask

    // Walk the vector table the way the run is described to behave.
    task automatic model_run(input bit stop, output int n, output int errs, output int fail,
                             output int cyc, output logic [CW-1:0] last_cw);
        bit mm;
        exp_q.delete();
        n = 0; errs = 0; fail = 0; last_cw = Ctrl_Out;
        for (int a = 0; a < DEPTH; a++) begin
            if (!m_valid[a]) begin
                cyc = LAT * n + 3;
                return;
            end
            exp_q.push_back(m_cw[a]);
            last_cw = m_cw[a];
            n++;
            mm = ((m_cw[a][OBS-1:0] ^ m_exp[a]) & m_mask[a]) != 0;
            if (mm) begin
                if (errs == 0) fail = a;
                errs++;
                if (stop) begin
                    cyc = LAT * n + 1;
                    return;
                end
            end
        end
        cyc = LAT * n + 1;
    endtask

    // co_load writes Load_Addr/Load_Data in the Start cycle; poke writes while busy.
    task automatic run(input string tag, input bit stop, input bit co_load, input bit poke);
        int n, errs, fail, cyc, cycles;
        logic [CW-1:0] last_cw;
        model_run(stop, n, errs, fail, cyc, last_cw);
        @(negedge Clock);
        Start = 1'b1; Stop_On_Err = stop; Load_En = co_load;
        @(negedge Clock);
        Start = 1'b0; Stop_On_Err = 1'($urandom); Load_En = 1'b0;
        cycles = 1;
        while (!Done && cycles < LAT * DEPTH + 10) begin
            if (poke && cycles == 3) begin
                Load_En = 1'b1; Load_Addr = AW'(1);
                Load_Data = {1'b1, EW'({$urandom(), $urandom()})} ;
            end else begin
                Load_En = 1'b0;
            end
            @(negedge Clock);
            cycles++;
        end
        Load_En = 1'b0;
        check({tag, "_cycles"}, 64'(cycles), 64'(cyc));
        check({tag, "_done"}, 64'(Done), 64'd1);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_vec"}, 64'(Vec_Count), 64'(n));
        check({tag, "_err"}, 64'(Err_Count), 64'(errs));
        check({tag, "_fail_addr"}, 64'(Fail_Addr), 64'(fail));
        check({tag, "_pass"}, 64'(Pass), 64'(errs == 0));
        check({tag, "_ctrl_valid"}, 64'(Ctrl_Valid), 64'd0);
        check({tag, "_ctrl_out"}, 64'(Ctrl_Out), 64'(last_cw));
        check({tag, "_trace_left"}, 64'(exp_q.size()), 64'd0);
        @(negedge Clock);
        check({tag, "_done_hold"}, 64'(Done), 64'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ctrl_out"}, 64'(Ctrl_Out), 64'd0);
        check({tag, "_ctrl_valid"}, 64'(Ctrl_Valid), 64'd0);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_done"}, 64'(Done), 64'd0);
        check({tag, "_pass"}, 64'(Pass), 64'd0);
        check({tag, "_err"}, 64'(Err_Count), 64'd0);
        check({tag, "_vec"}, 64'(Vec_Count), 64'd0);
        check({tag, "_fail_addr"}, 64'(Fail_Addr), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    initial begin
        logic [CW-1:0]  cw;
        logic [OBS-1:0] e, m;
        int steps, nvalid;
        tests_run = 0; tests_failed = 0;
        Reset = 1'b0; Load_En = 1'b0; Start = 1'b0; Stop_On_Err = 1'b0;
        Load_Addr = '0; Load_Data = '0;
        for (int a = 0; a < DEPTH; a++) set_model(a, 1'b0, '0, '0, '0);
        repeat (3) @(negedge Clock);
        check_cleared("reset");
        Reset = 1'b1;

        // Three echoing vectors followed by an end marker.
        for (int a = 0; a < 3; a++) load(a, 1'b1, CW'(a + 1), 8'(a + 1), 8'hFF);
        load(3, 1'b0, '0, '0, '0);
        run("basic", 1'b0, 1'b0, 1'b0);

        load(1, 1'b1, CW'(2), 8'h55, 8'hFF);
        run("one_err", 1'b0, 1'b0, 1'b0);
        run("stop_err", 1'b1, 1'b0, 1'b0);

        for (int a = 0; a < DEPTH; a++) begin
            cw = CW'({$urandom(), $urandom()});
            load(a, 1'b1, cw, cw[OBS-1:0], 8'hFF);
        end
        run("full_wrap", 1'b0, 1'b0, 1'b0);

        // Only the low nibble is compared; a write while busy must not land.
        load(0, 1'b1, {CW'($urandom()) & ~CW'(8'hFF)} | CW'(8'hA5), 8'h05, 8'h0F);
        load(1, 1'b0, '0, '0, '0);
        run("mask_poke", 1'b0, 1'b0, 1'b1);
        cw = {CW'($urandom()) << 8} | CW'(8'hA5);
        set_model(0, 1'b1, cw, 8'h05, 8'h0F);
        Load_Addr = '0; Load_Data = {1'b1, cw, 8'h05, 8'h0F};
        run("start_load", 1'b0, 1'b1, 1'b0);

        // Abort mid-settle, then rerun the same table from address 0.
        for (int a = 0; a < 3; a++) load(a, 1'b1, CW'(a + 1), 8'(a + 1), 8'hFF);
        load(3, 1'b0, '0, '0, '0);
        @(negedge Clock); Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        steps = 0;
        while (dbg_state != ST_SETTLE_W && steps < 20) begin
            @(negedge Clock);
            steps++;
        end
        check("abort_reach_settle", 64'(dbg_state), 64'(ST_SETTLE_W));
        Reset = 1'b0;
        @(negedge Clock);
        check_cleared("abort");
        Reset = 1'b1;
        run("rerun", 1'b0, 1'b0, 1'b0);

        // Randomized tables: random length, expectations, masks and stop mode.
        for (int k = 0; k < 6; k++) begin
            nvalid = $urandom_range(1, DEPTH);
            for (int a = 0; a < DEPTH; a++) begin
                cw = CW'({$urandom(), $urandom()});
                e  = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : cw[OBS-1:0];
                m  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom());
                load(a, a < nvalid, cw, e, m);
            end
            run($sformatf("rand%0d", k), 1'($urandom()), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- On-chip, synthesizable successor to the vector-driven ALU system bench: stores packed control words with expected outputs in an internal vector RAM.
- Replays the words one per step into the ALU system datapath and checks a masked observed bus after a programmable settle time.
- Counts mismatches, captures the first failing address, and terminates on an end-marker entry, on the last address, or optionally on the first error.
- Sits between the host load interface and the ALU system control inputs.

Parameters:
- CW_WIDTH, 41, width of one packed control word driven to the datapath.
- OBS_WIDTH, 8, width of the observed datapath bus (e.g. ALU_Out).
- DEPTH, 64, number of vector entries; power of two, at least 2.
- SETTLE, 1, cycles between Ctrl_Out update and the compare; range 0..15.
- ADDR_W, $clog2(DEPTH), vector address width (derived).
- ENTRY_W, 1+CW_WIDTH+2*OBS_WIDTH, packed entry width {valid, cw, expect, mask} (derived).

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low
- Load_En  in  1  write one entry this cycle
- Load_Addr  in  ADDR_W  entry address
- Load_Data  in  ENTRY_W  packed {valid, cw, expect, mask}
- Start  in  1  begin a run from address 0
- Stop_On_Err  in  1  sampled at Start; halt on first mismatch
- Obs_In  in  OBS_WIDTH  datapath observation
- Ctrl_Out  out  CW_WIDTH  control word applied to datapath
- Ctrl_Valid  out  1  Ctrl_Out holds a live vector
- Busy  out  1  run in progress
- Done  out  1  run finished; held until Start or Reset
- Pass  out  1  Done and Err_Count==0
- Err_Count  out  ADDR_W+1  mismatch count, saturating
- Vec_Count  out  ADDR_W+1  vectors checked
- Fail_Addr  out  ADDR_W  address of first mismatch

Behaviour:
- Reset (Reset==0 at a Clock edge) clears all outputs and state:
  - Ctrl_Out=0, Ctrl_Valid=0, Busy=0, Done=0, Pass=0, Err_Count=0, Vec_Count=0, Fail_Addr=0, state IDLE.
  - Reset does not clear the RAM contents.
  - Reset mid-run aborts the run immediately.
- RAM: DEPTH x ENTRY_W, synchronous write, synchronous read with 1-cycle latency.
  - Load_En is honoured only when Busy==0; it is ignored while Busy.
- States: IDLE, FETCH, APPLY, SETTLE_W, CHECK, DONE.
- IDLE/DONE on Start:
  - ptr=0; counters and Fail_Addr cleared; Done=0; Busy=1; Stop_On_Err latched; go to FETCH.
  - Start in any other state is ignored.
- FETCH: issue read of ptr; go to APPLY on the next cycle.
- APPLY (entry available):
  - valid==0 is the end marker: go to DONE, Ctrl_Valid=0.
  - Otherwise register Ctrl_Out=cw and Ctrl_Valid=1, latch expect and mask, load the settle counter with SETTLE, and go to SETTLE_W (or directly to CHECK when SETTLE==0).
- SETTLE_W: decrement the counter each cycle; go to CHECK when it reaches 1.
- CHECK: mismatch = |((Obs_In ^ expect) & mask).
  - Vec_Count increments by 1.
  - On mismatch, Err_Count increments, saturating at all-ones.
  - On the first mismatch of a run, Fail_Addr=ptr.
  - Next state:
    - ptr==DEPTH-1, or (mismatch and latched Stop_On_Err): go to DONE.
    - Otherwise ptr++ and go to FETCH.
- Ctrl_Out and Ctrl_Valid hold their value through SETTLE_W and CHECK, and hold the last word through FETCH and APPLY of the next entry.
- DONE:
  - Busy=0, Done=1, Ctrl_Valid=0; Ctrl_Out keeps its last value.
  - Pass = (Err_Count==0), valid while Done.
- Per-vector latency is SETTLE+3 cycles: FETCH, APPLY, SETTLE cycles, CHECK.
- A mask of 0 always passes.
- Load_En with Start in the same idle cycle: the write completes, and the run reads the new value because the read is one cycle later.

Decomposition:
- Shared package vseq_pkg holds:
  - the state enum;
  - entry field offset constants (VALID_BIT, CW_LSB, EXP_LSB, MASK_LSB) as functions of the parameters.
- One sub-module, vseq_ram: parametrised simple dual-port RAM with 1-cycle synchronous read.
- The FSM, counters and compare logic stay in vector_sequencer.

Test Plan:
- Load entries 0..2 (cw=1,2,3; expect=cw; mask=FF), entry 3 valid=0, Obs_In echoes cw[7:0], SETTLE=1, Start -> Ctrl_Out steps 1,2,3 at 4-cycle spacing; Done at end marker with Vec_Count=3, Err_Count=0, Pass=1.
- Same load, entry 1 expect=0x55, Stop_On_Err=0 -> run completes with Err_Count=1, Fail_Addr=1, Vec_Count=3, Pass=0.
- Same as previous with Stop_On_Err=1 -> Done right after checking entry 1; Vec_Count=2; Ctrl_Valid=0.
- All DEPTH entries valid and matching -> wrap at DEPTH-1 terminates the run; Vec_Count=DEPTH, Pass=1.
- Mask=0x0F, expect=0x05, Obs_In=0xA5 -> no error; Load_En while Busy leaves the RAM unchanged (verified by a second run).
- Reset asserted low mid-SETTLE_W -> next cycle all outputs 0 and state IDLE; a following Start reruns from address 0 with identical results.
